// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex 8N1 UART with a byte FIFO in front of the
// transmitter and behind the receiver. The bit period is a runtime divisor
// (clock cycles per bit), latched at the start of every frame.
`timescale 1ns/1ps
module uart_fifo_core #(
  parameter int FIFO_DEPTH = 32,
  parameter int RX_ENABLE  = 1,
  parameter int TX_ENABLE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baud_div,
  input  logic        uart_tx_start,
  input  logic [7:0]  uart_tx_data_in,
  output logic        uart_tx_pin,
  input  logic        uart_rx_pin,
  input  logic        uart_rx_read,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_rx_byte
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Divisors below 4 leave too few cycles for mid-bit sampling, so clamp them.
  logic [15:0] div_eff;
  assign div_eff = (baud_div < 16'd4) ? 16'd4 : baud_div;

  generate
    if (TX_ENABLE != 0) begin : g_tx
      logic [7:0]    tx_mem [FIFO_DEPTH];
      logic [7:0]    data_reg;
      logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [AW:0]   count_reg;
      uart_state_t   state_reg, state_next;
      logic [15:0]   div_reg, div_next, cnt_reg, cnt_next;
      logic [2:0]    bit_reg, bit_next;
      logic          pin_reg, pin_next;
      logic          push, pop, bit_done;

      assign push        = uart_tx_start && (count_reg != FULL);
      assign bit_done    = (cnt_reg == div_reg - 16'd1);
      assign uart_tx_pin = pin_reg;

      // FIFO storage: write accepted pushes, registered read of the head on pop
      always_ff @(posedge clk) begin
        if (push) tx_mem[wr_ptr_reg] <= uart_tx_data_in;
        if (pop)  data_reg <= tx_mem[rd_ptr_reg];
      end

      // Transmit engine next-state: pop in IDLE, then start/8 data/stop bits
      always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        pin_next   = pin_reg;
        pop        = 1'b0;
        case (state_reg)
          IDLE: begin
            pin_next = 1'b1;
            if (count_reg != '0) begin
              pop        = 1'b1;
              state_next = START;
              div_next   = div_eff;
              cnt_next   = '0;
              pin_next   = 1'b0;
            end
          end
          START: begin
            if (bit_done) begin
              state_next = DATA;
              cnt_next   = '0;
              bit_next   = '0;
              pin_next   = data_reg[0];
            end else begin
              cnt_next = cnt_reg + 16'd1;
            end
          end
          DATA: begin
            if (bit_done) begin
              cnt_next = '0;
              if (bit_reg == 3'd7) begin
                state_next = STOP;
                pin_next   = 1'b1;
              end else begin
                bit_next = bit_reg + 3'd1;
                pin_next = data_reg[bit_reg + 3'd1];
              end
            end else begin
              cnt_next = cnt_reg + 16'd1;
            end
          end
          STOP: begin
            if (bit_done) state_next = IDLE;
            else          cnt_next   = cnt_reg + 16'd1;
          end
          default: begin
            state_next = IDLE;
            pin_next   = 1'b1;
          end
        endcase
      end

      // Engine state and FIFO pointer/occupancy registers
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg  <= IDLE;
          div_reg    <= 16'd4;
          cnt_reg    <= '0;
          bit_reg    <= '0;
          pin_reg    <= 1'b1;
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          state_reg <= state_next;
          div_reg   <= div_next;
          cnt_reg   <= cnt_next;
          bit_reg   <= bit_next;
          pin_reg   <= pin_next;
          if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
          if (push && !pop)      count_reg <= count_reg + (AW+1)'(1);
          else if (!push && pop) count_reg <= count_reg - (AW+1)'(1);
        end
      end
    end else begin : g_no_tx
      assign uart_tx_pin = 1'b1;
    end

    if (RX_ENABLE != 0) begin : g_rx
      logic [7:0]    rx_mem [FIFO_DEPTH];
      logic [7:0]    byte_reg;
      logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [AW:0]   count_reg;
      logic [2:0]    sync_reg;  // [0],[1] synchronizer; [2] previous synchronized value
      uart_state_t   state_reg, state_next;
      logic [15:0]   div_reg, div_next, cnt_reg, cnt_next;
      logic [2:0]    bit_reg, bit_next;
      logic [7:0]    shift_reg, shift_next;
      logic          done, push, pop, rx_bit, bit_done;

      assign rx_bit        = sync_reg[1];
      assign bit_done      = (cnt_reg == div_reg - 16'd1);
      assign push          = done && (count_reg != FULL);
      assign pop           = uart_rx_read && (count_reg != '0);
      assign uart_rx_ready = (count_reg != '0);
      assign uart_rx_byte  = byte_reg;

      // Bring the asynchronous pin into the clock domain and keep one history bit
      always_ff @(posedge clk) begin
        if (rst) sync_reg <= 3'b111;
        else     sync_reg <= {sync_reg[1:0], uart_rx_pin};
      end

      // FIFO storage: completed bytes are written from the shift register
      always_ff @(posedge clk) begin
        if (push) rx_mem[wr_ptr_reg] <= shift_reg;
      end

      // Registered read port doubles as the user-visible last-popped byte
      always_ff @(posedge clk) begin
        if (rst)      byte_reg <= '0;
        else if (pop) byte_reg <= rx_mem[rd_ptr_reg];
      end

      // Receive engine next-state: mid-bit sampling, glitch and framing rejection
      always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        done       = 1'b0;
        case (state_reg)
          IDLE: begin
            if (sync_reg[2] && !sync_reg[1]) begin
              state_next = START;
              div_next   = div_eff;
              cnt_next   = '0;
            end
          end
          START: begin
            if (cnt_reg == (div_reg >> 1) - 16'd1) begin
              cnt_next   = '0;
              bit_next   = '0;
              state_next = rx_bit ? IDLE : DATA;
            end else begin
              cnt_next = cnt_reg + 16'd1;
            end
          end
          DATA: begin
            if (bit_done) begin
              cnt_next   = '0;
              shift_next = {rx_bit, shift_reg[7:1]};
              if (bit_reg == 3'd7) state_next = STOP;
              else                 bit_next   = bit_reg + 3'd1;
            end else begin
              cnt_next = cnt_reg + 16'd1;
            end
          end
          STOP: begin
            if (bit_done) begin
              state_next = IDLE;
              done       = rx_bit;
            end else begin
              cnt_next = cnt_reg + 16'd1;
            end
          end
          default: state_next = IDLE;
        endcase
      end

      // Engine state and FIFO pointer/occupancy registers
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg  <= IDLE;
          div_reg    <= 16'd4;
          cnt_reg    <= '0;
          bit_reg    <= '0;
          shift_reg  <= '0;
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          state_reg <= state_next;
          div_reg   <= div_next;
          cnt_reg   <= cnt_next;
          bit_reg   <= bit_next;
          shift_reg <= shift_next;
          if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
          if (push && !pop)      count_reg <= count_reg + (AW+1)'(1);
          else if (!push && pop) count_reg <= count_reg - (AW+1)'(1);
        end
      end
    end else begin : g_no_rx
      assign uart_rx_ready = 1'b0;
      assign uart_rx_byte  = 8'h00;
    end
  endgenerate

endmodule

// File: tb/tb_uart_fifo_core.sv
// Bench for uart_fifo_core: directed steps with random payloads, checked
// against queue models of the serial line and of the two FIFOs.
`timescale 1ns/1ps
module tb_uart_fifo_core;
  localparam int DEPTH = 32;

  logic        clk;
  logic        rst;
  logic [15:0] baud_div;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data_in;
  logic        uart_tx_pin;
  logic        uart_rx_pin;
  logic        uart_rx_read;
  logic        uart_rx_ready;
  logic [7:0]  uart_rx_byte;

  int total = 0;
  int bad   = 0;

  int   mon_div = 16;
  logic mon_en  = 1'b0;
  logic [9:0] tx_seen [$];  // {stop_ok, start_ok, data} decoded from the TX pin
  logic [9:0] tx_exp  [$];
  logic [7:0] rx_exp  [$];

  uart_fifo_core #(.FIFO_DEPTH(DEPTH), .RX_ENABLE(1), .TX_ENABLE(1)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div),
    .uart_tx_start(uart_tx_start), .uart_tx_data_in(uart_tx_data_in),
    .uart_tx_pin(uart_tx_pin), .uart_rx_pin(uart_rx_pin),
    .uart_rx_read(uart_rx_read), .uart_rx_ready(uart_rx_ready),
    .uart_rx_byte(uart_rx_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
    uart_rx_pin = 1'b0;
    tick(div);
    for (int i = 0; i < 8; i++) begin
      uart_rx_pin = b[i];
      tick(div);
    end
    uart_rx_pin = stop;
    tick(div);
    uart_rx_pin = 1'b1;
  endtask

  task automatic rx_read(output logic [7:0] b, output logic rdy);
    uart_rx_read = 1'b1;
    tick(1);
    uart_rx_read = 1'b0;
    b   = uart_rx_byte;
    rdy = uart_rx_ready;
  endtask

  task automatic wait_ready(input int limit, input string tag);
    int n;
    n = 0;
    while (uart_rx_ready !== 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
    check(tag, 32'(uart_rx_ready), 32'd1);
  endtask

  task automatic tx_push(input logic [7:0] b);
    uart_tx_start   = 1'b1;
    uart_tx_data_in = b;
    tick(1);
    uart_tx_start   = 1'b0;
  endtask

  task automatic compare_tx(input string tag);
    check({tag, "_count"}, 32'(tx_seen.size()), 32'(tx_exp.size()));
    while (tx_exp.size() > 0 && tx_seen.size() > 0)
      check(tag, 32'(tx_seen.pop_front()), 32'(tx_exp.pop_front()));
    tx_seen.delete();
    tx_exp.delete();
  endtask

  // Serial-line decoder for the TX pin: mid-bit sampling at mon_div cycles per bit
  initial begin : tx_monitor
    logic [7:0] d;
    logic       s0, s1;
    forever begin
      @(negedge clk);
      if (mon_en && uart_tx_pin === 1'b0) begin
        repeat (mon_div / 2) @(negedge clk);
        s0 = uart_tx_pin;
        for (int b = 0; b < 8; b++) begin
          repeat (mon_div) @(negedge clk);
          d[b] = uart_tx_pin;
        end
        repeat (mon_div) @(negedge clk);
        s1 = uart_tx_pin;
        tx_seen.push_back({s1, ~s0, d});
      end
    end
  end

  initial begin : main
    logic [7:0] b, got, last, pat;
    logic [7:0] echo [5];
    logic       rdy, expv;
    int         low_at, errs, occ;

    rst = 1'b1; baud_div = 16'd16; uart_tx_start = 1'b0; uart_tx_data_in = 8'h00;
    uart_rx_pin = 1'b1; uart_rx_read = 1'b0;
    tick(5);
    check("reset_tx_pin",   32'(uart_tx_pin),   32'd1);
    check("reset_rx_ready", 32'(uart_rx_ready), 32'd0);
    check("reset_rx_byte",  32'(uart_rx_byte),  32'd0);
    rst = 1'b0;
    tick(3);

    // 0x55 at divisor 1736: start latency and exact bit widths
    baud_div = 16'd1736;
    pat = 8'h55;
    tx_push(pat);
    low_at = 0;
    while (uart_tx_pin !== 1'b0 && low_at < 3) begin
      tick(1);
      low_at++;
    end
    check("tx_start_within_2", 32'(low_at <= 1), 32'd1);
    for (int bitn = 0; bitn < 10; bitn++) begin
      if (bitn == 0)      expv = 1'b0;
      else if (bitn == 9) expv = 1'b1;
      else                expv = pat[bitn-1];
      errs = 0;
      for (int c = 0; c < 1736; c++) begin
        if (uart_tx_pin !== expv) errs++;
        tick(1);
      end
      check($sformatf("tx55_bit%0d_bad_cycles", bitn), 32'(errs), 32'd0);
    end
    errs = 0;
    for (int c = 0; c < 300; c++) begin
      if (uart_tx_pin !== 1'b1) errs++;
      tick(1);
    end
    check("tx55_idle_high", 32'(errs), 32'd0);

    // Single RX frame 0xA3, then a one-cycle read
    baud_div = 16'd16;
    send_frame(8'hA3, 1'b1, 16);
    wait_ready(40, "rx_a3_ready");
    rx_read(got, rdy);
    check("rx_a3_byte",       32'(got), 32'hA3);
    check("rx_a3_ready_after", 32'(rdy), 32'd0);

    // Echo loop: each received byte is pushed back out on TX
    mon_div = 16;
    mon_en  = 1'b1;
    echo[0] = 8'h00; echo[1] = 8'hFF; echo[2] = 8'h41;
    echo[3] = 8'($urandom); echo[4] = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      send_frame(echo[i], 1'b1, 16);
      wait_ready(40, "echo_rx_ready");
      rx_read(got, rdy);
      check("echo_rx_byte", 32'(got), 32'(echo[i]));
      tx_push(got);
      tx_exp.push_back({2'b11, echo[i]});
    end
    tick(600);
    compare_tx("echo_tx_frame");

    // TX overflow: engine busy with one byte, then a 33-cycle held push
    b = 8'($urandom);
    tx_push(b);
    tx_exp.push_back({2'b11, b});
    tick(5);
    occ = 0;
    uart_tx_start = 1'b1;
    for (int i = 0; i < 33; i++) begin
      b = 8'($urandom);
      uart_tx_data_in = b;
      if (occ < DEPTH) begin
        tx_exp.push_back({2'b11, b});
        occ++;
      end
      tick(1);
    end
    uart_tx_start = 1'b0;
    tick(34 * 165 + 200);
    compare_tx("tx_ovf_frame");
    mon_en = 1'b0;

    // RX overflow: 33 frames with no reads; only the first DEPTH are kept
    for (int i = 0; i < 33; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 16);
      if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
    end
    check("rx_ovf_ready", 32'(uart_rx_ready), 32'd1);
    last = 8'h00;
    while (rx_exp.size() > 0) begin
      rx_read(got, rdy);
      last = rx_exp.pop_front();
      check("rx_ovf_byte", 32'(got), 32'(last));
    end
    check("rx_ovf_drained_ready", 32'(uart_rx_ready), 32'd0);
    rx_read(got, rdy);
    check("empty_read_byte_held", 32'(got), 32'(last));
    check("empty_read_ready",     32'(rdy), 32'd0);

    // 0.3-bit glitch and a framing error must not produce a byte
    uart_rx_pin = 1'b0;
    tick(5);
    uart_rx_pin = 1'b1;
    tick(100);
    check("glitch_no_byte", 32'(uart_rx_ready), 32'd0);
    send_frame(8'($urandom), 1'b0, 16);
    tick(48);
    check("framing_err_no_byte", 32'(uart_rx_ready), 32'd0);
    send_frame(8'h3C, 1'b1, 16);
    wait_ready(40, "after_err_ready");
    rx_read(got, rdy);
    check("after_err_byte", 32'(got), 32'h3C);

    // Reset mid-TX frame with data queued in both FIFOs
    send_frame(8'h5A, 1'b1, 16);
    check("pre_rst_rx_ready", 32'(uart_rx_ready), 32'd1);
    tx_push(8'h12);
    tx_push(8'h34);
    tx_push(8'h56);
    while (uart_tx_pin !== 1'b1 && errs < 0) tick(1);
    tick(60);
    rst = 1'b1;
    tick(1);
    check("rst_mid_tx_pin",   32'(uart_tx_pin),   32'd1);
    check("rst_mid_rx_ready", 32'(uart_rx_ready), 32'd0);
    check("rst_mid_rx_byte",  32'(uart_rx_byte),  32'd0);
    rst = 1'b0;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      if (uart_tx_pin !== 1'b1) errs++;
      tick(1);
    end
    check("rst_tx_fifo_empty", 32'(errs), 32'd0);
    rx_read(got, rdy);
    check("rst_empty_read_byte", 32'(got), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo_core.md
Name: uart_fifo_core

Overview:
- Full-duplex 8N1 UART with a configurable TX FIFO and RX FIFO; the bit period is set at runtime by a clocks-per-bit divisor.
- User logic pushes bytes into the TX FIFO and pops received bytes from the RX FIFO with single-cycle strobes.
- Sits between a PLL-clocked fabric domain and the board serial pins. Typical use: 200 MHz clock, divisor 1736 for 115200 baud.

Parameters:
- FIFO_DEPTH, 32, entries in each of the TX and RX FIFOs. Must be a power of two, at least 2.
- RX_ENABLE, 1, 1 builds the receiver and RX FIFO; 0 removes them.
- TX_ENABLE, 1, 1 builds the transmitter and TX FIFO; 0 removes them.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- baud_div  input  16  clock cycles per serial bit.
- uart_tx_start  input  1  push strobe for the TX FIFO.
- uart_tx_data_in  input  8  byte to push.
- uart_tx_pin  output  1  serial TX line; idle high.
- uart_rx_pin  input  1  serial RX line; asynchronous.
- uart_rx_read  input  1  pop strobe for the RX FIFO.
- uart_rx_ready  output  1  RX FIFO non-empty.
- uart_rx_byte  output  8  last popped byte, registered.

Behaviour:
- Reset, held over any edge:
  - uart_tx_pin=1, uart_rx_ready=0, uart_rx_byte=0.
  - Both FIFOs empty; both engines idle.
  - Reset mid-frame aborts the frame; the TX pin is high on the next cycle.
- Divisor:
  - baud_div is latched at the start of each TX or RX frame.
  - Values below 4 are treated as 4.
- Frame format: 8N1, LSB first. Start bit 0, 8 data bits, stop bit 1; each bit lasts exactly baud_div cycles.
- TX FIFO push:
  - Each edge with uart_tx_start=1 pushes uart_tx_data_in.
  - A level held for N cycles pushes N bytes.
  - Push while the FIFO is full is dropped; FIFO contents are unchanged.
- TX engine:
  - States: IDLE, START, DATA (bit counter 0..7), STOP.
  - IDLE with FIFO non-empty: pop the head byte and enter START.
  - A byte pushed at edge k into an empty FIFO with the engine idle drives the pin low no later than edge k+2.
  - After the full STOP period, the next queued byte's start bit follows within 1 cycle.
- RX front end:
  - uart_rx_pin passes through a 2-flop synchronizer.
  - IDLE: a synchronized 1->0 transition enters START.
- RX engine:
  - START samples at baud_div/2 cycles. If the line is high, it is a glitch: return to IDLE. Otherwise enter DATA.
  - DATA samples each bit baud_div cycles after the previous sample (mid-bit); the bits are shifted LSB first.
  - STOP samples mid-bit:
    - 1: write the byte to the RX FIFO.
    - 0: framing error; discard the byte.
  - After STOP, return to IDLE immediately, without waiting for the end of the stop bit.
  - A completed byte while the RX FIFO is full is dropped.
- RX FIFO pop:
  - uart_rx_ready = RX FIFO non-empty.
  - An edge with uart_rx_read=1 and a non-empty FIFO pops the head into the uart_rx_byte register. The value is visible the cycle after the read edge and holds until the next successful pop.
  - A read on an empty FIFO is ignored; uart_rx_byte is unchanged.
  - uart_rx_ready reflects the post-pop occupancy one cycle after the read edge.
  - A simultaneous RX write and pop both take effect; occupancy is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. A log2(FIFO_DEPTH)+1-bit occupancy count distinguishes full from empty.
- TX_ENABLE=0: uart_tx_pin is constant 1 and uart_tx_start is ignored.
- RX_ENABLE=0: uart_rx_ready=0 and uart_rx_byte=0 permanently; uart_rx_read is ignored.

Test Plan:
- Reset, then baud_div=1736 and a 1-cycle start with 0x55 -> pin low within 2 cycles. Bits 0,1,0,1,0,1,0,1 (LSB first), then stop=1, each 1736 cycles wide; the pin stays high afterwards.
- Drive RX frame 0xA3 at baud_div=16 -> uart_rx_ready=1 after the stop bit. A 1-cycle read gives uart_rx_byte=0xA3 the next cycle and uart_rx_ready=0 one cycle later.
- Echo loop, baud_div=16: RX 0x00, 0xFF, 0x41 -> the same bytes appear on TX in order, with correct framing.
- Push 33 bytes while TX is busy with FIFO_DEPTH=32 -> exactly 32 transmitted, or 33 if the engine already popped the first; no corruption. Receive 33 frames without reading -> 32 stored, the extra dropped.
- A 0.3-bit low glitch on RX gives no byte. A frame with stop=0 is discarded; uart_rx_ready stays 0.
- Assert rst mid-TX frame -> the pin is 1 the next cycle and the FIFOs are empty. Read with the RX FIFO empty -> uart_rx_byte is unchanged.
